serial_number_receiver: RTL

Upstream stage of the impulse generator. Receives 8-bit values over an asynchronous serial line (start bit, 8 data bits LSB first, stop bit). Holds each received value in a one-entry buffer. Serves the value to the downstream consumer as numero through the soc/eoc handshake, with this block acting as the producer.

---
 rtl/serial_number_receiver.sv | 101 ++++++++++
 1 files changed

// File: rtl/serial_number_receiver.sv
// serial_number_receiver: UART-style byte receiver with a one-entry buffer served over a soc/eoc handshake
module serial_number_receiver #(
    parameter int BIT_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    input  logic       soc,
    output logic       eoc,
    output logic [7:0] numero,
    output logic       overrun,
    output logic       frame_err
);
    localparam int CW = $clog2(BIT_CYCLES) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(BIT_CYCLES - 1);
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
    typedef enum logic {H_IDLE, H_ACK} h_t;
    rx_t rx_state, rx_next;
    h_t h_state, h_next;
    logic rx_meta, rxs, rxs_q;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0] idx, idx_next;
    logic [7:0] shreg, shreg_next, buf_data;
    logic buf_full, stop_ok, stop_bad, deliver, store;
    // two-flop synchronizer plus one delay stage for falling-edge detection, idle high
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
            rxs_q   <= rxs;
        end
    end
    // receiver next state: half-bit start check, then mid-bit sampling of data and stop
    always_comb begin
        rx_next    = rx_state;
        cnt_next   = cnt + 1'b1;
        idx_next   = idx;
        shreg_next = shreg;
        stop_ok    = 1'b0;
        stop_bad   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                cnt_next = '0;
                if (rxs_q && !rxs) rx_next = RX_START;
            end
            RX_START: if (cnt == HALF_LAST) begin
                cnt_next = '0;
                idx_next = 3'd0;
                rx_next  = rxs ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt == FULL_LAST) begin
                cnt_next        = '0;
                shreg_next[idx] = rxs;
                idx_next        = idx + 3'd1;
                if (idx == 3'd7) rx_next = RX_STOP;
            end
            RX_STOP: if (cnt == FULL_LAST) begin
                cnt_next = '0;
                stop_ok  = rxs;
                stop_bad = !rxs;
                rx_next  = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end
    assign deliver = (h_state == H_ACK) && !soc && buf_full;
    assign store   = stop_ok && (!buf_full || deliver);
    assign h_next  = (h_state == H_IDLE) ? (soc ? H_ACK : H_IDLE) : (deliver ? H_IDLE : H_ACK);
    assign eoc     = (h_state == H_IDLE);
    // state registers, buffer and delivery; a delivery frees the buffer for a same-cycle store
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state  <= RX_IDLE;
            h_state   <= H_IDLE;
            cnt       <= '0;
            idx       <= 3'd0;
            shreg     <= 8'h00;
            buf_data  <= 8'h00;
            buf_full  <= 1'b0;
            numero    <= 8'h00;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_state  <= rx_next;
            h_state   <= h_next;
            cnt       <= cnt_next;
            idx       <= idx_next;
            shreg     <= shreg_next;
            frame_err <= stop_bad;
            buf_full  <= store || (buf_full && !deliver);
            if (store) buf_data <= shreg;
            if (deliver) numero <= buf_data;
            if (stop_ok && buf_full && !deliver) overrun <= 1'b1;
        end
    end
endmodule
